// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// Holds the FSM encoding, requester IDs and the default timeout.
`default_nettype none

package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } arb_state_t;

    localparam logic        REQ_IF             = 1'b0;
    localparam logic        REQ_LS             = 1'b1;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned WAIT_CNT_W         = 16;

endpackage

`default_nettype wire

// File: rtl/mem_port_arb_timer.sv
// Saturating 16-bit wait counter; expired_o flags that the cycle being
// counted now is the one that reaches TIMEOUT_CYCLES.
`default_nettype none

module mem_port_arb_timer
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  enable_i,
    output logic [WAIT_CNT_W-1:0] count_o,
    output logic                  expired_o
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = enable_i && (({1'b0, count_q} + 1'b1) >= {1'b0, LIMIT});

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store. Optional wait timeout enabled by MEM_PORT_ARB_TIMEOUT_EN.
`default_nettype none

module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_wmask_i,
    output logic [31:0] ls_rdata_o,
    output logic        ls_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic        bus_err_o
);

    arb_state_t  state_q, state_d;
    logic        last_q, last_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        ls_ack_q, ls_ack_d;
    logic        bus_err_q, bus_err_d;

    logic        w_if_pend;
    logic        w_ls_pend;
    logic        w_busy;
    logic        w_abort;

    // A requester being acknowledged this cycle is still holding its request.
    assign w_if_pend = if_req_i & ~if_ack_q;
    assign w_ls_pend = ls_req_i & ~ls_ack_q;
    assign w_busy    = (state_q != ST_IDLE);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] w_wait_cnt;
    logic                  w_expired;

    mem_port_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (~w_busy),
        .enable_i  (w_busy & ~mem_ack_i),
        .count_o   (w_wait_cnt),
        .expired_o (w_expired)
    );

    assign w_abort = w_expired;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_ls_pend && (!w_if_pend || (last_q == REQ_IF))) begin
                    state_d     = ST_BUSY_LS;
                    last_d      = REQ_LS;
                    mem_we_d    = ls_we_i;
                    mem_addr_d  = ls_addr_i;
                    mem_wdata_d = ls_wdata_i;
                    mem_wmask_d = ls_we_i ? ls_wmask_i : 4'h0;
                end else if (w_if_pend) begin
                    state_d     = ST_BUSY_IF;
                    last_d      = REQ_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = 32'h0;
                    mem_wmask_d = 4'h0;
                end
            end
            ST_BUSY_IF, ST_BUSY_LS: begin
                if (mem_ack_i || w_abort) begin
                    state_d   = ST_IDLE;
                    bus_err_d = ~mem_ack_i;
                    if (state_q == ST_BUSY_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_ack_i ? mem_rdata_i : 32'h0;
                    end else begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = mem_ack_i ? mem_rdata_i : 32'h0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= REQ_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'h0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req_o   = w_busy;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_ack_o    = ls_ack_q;
    assign bus_err_o   = bus_err_q;
    assign stall_o     = w_if_pend | w_ls_pend;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written round-robin, timeout and mid-access reset sequences.
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ack_o    (if_ack),
        .ls_req_i    (ls_req),
        .ls_we_i     (ls_we),
        .ls_addr_i   (ls_addr),
        .ls_wdata_i  (ls_wdata),
        .ls_wmask_i  (ls_wmask),
        .ls_rdata_o  (ls_rdata),
        .ls_ack_o    (ls_ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wmask_o (mem_wmask),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stall_o     (stall),
        .bus_err_o   (bus_err)
    );

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        lsr;
        logic        lswe;
        logic [31:0] lsa;
        logic [31:0] lswd;
        logic [3:0]  lsm;
        logic        mack;
        logic [31:0] mrd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_wm;
        logic        e_ifack;
        logic        e_lsack;
        logic        e_stall;
        logic [31:0] e_ifrd;
        logic [31:0] e_lsrd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic exp_ls;

        // IF-only fetch, memory acks on the third MEM_REQ cycle
        vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[2]  = vecs[1];
        vecs[3]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00A00093,
                     1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h0};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'h0};
        // simultaneous IF + LS store: LS wins the first tie
        vecs[6]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
        vecs[7]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF, 1'b1, 32'h11111111,
                     1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
        vecs[8]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0, 32'h0,
                     1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b1, 32'h00A00093, 32'h11111111};
        vecs[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D,
                     1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h11111111};
        vecs[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 32'h11111111};
        // stray MEM_ACK while idle must be ignored
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF,
                     1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h11111111};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h11111111};

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_wmask = '0; mem_rdata = '0; mem_ack = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst.mem_req", 32'(mem_req), 32'h0);
        chk("rst.if_ack",  32'(if_ack),  32'h0);
        chk("rst.ls_ack",  32'(ls_ack),  32'h0);
        chk("rst.bus_err", 32'(bus_err), 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.ls_rdata", ls_rdata, 32'h0);
        chk("rst.stall",   32'(stall),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if_req = vecs[i].ifr;  if_addr = vecs[i].ifa;
            ls_req = vecs[i].lsr;  ls_we = vecs[i].lswe; ls_addr = vecs[i].lsa;
            ls_wdata = vecs[i].lswd; ls_wmask = vecs[i].lsm;
            mem_ack = vecs[i].mack; mem_rdata = vecs[i].mrd;
            #1;
            chk($sformatf("v%0d.mem_req", i),   32'(mem_req),   32'(vecs[i].e_req));
            chk($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d.mem_addr", i),  mem_addr,       vecs[i].e_addr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata,      vecs[i].e_wd);
            chk($sformatf("v%0d.mem_wmask", i), 32'(mem_wmask), 32'(vecs[i].e_wm));
            chk($sformatf("v%0d.if_ack", i),    32'(if_ack),    32'(vecs[i].e_ifack));
            chk($sformatf("v%0d.ls_ack", i),    32'(ls_ack),    32'(vecs[i].e_lsack));
            chk($sformatf("v%0d.stall", i),     32'(stall),     32'(vecs[i].e_stall));
            chk($sformatf("v%0d.if_rdata", i),  if_rdata,       vecs[i].e_ifrd);
            chk($sformatf("v%0d.ls_rdata", i),  ls_rdata,       vecs[i].e_lsrd);
            chk($sformatf("v%0d.bus_err", i),   32'(bus_err),   32'h0);
        end

        // Both requesters held: grants alternate starting with LS
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_wdata = '0; ls_wmask = 4'hF;
        mem_ack = 1'b0;
        #1;
        chk("rr.stall_idle", 32'(stall), 32'h1);
        for (int k = 0; k < 6; k++) begin
            exp_ls = (k % 2 == 0);
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = 32'h5000 + 32'(k);
            #1;
            chk($sformatf("rr%0d.mem_req", k),  32'(mem_req), 32'h1);
            chk($sformatf("rr%0d.mem_addr", k), mem_addr, exp_ls ? 32'h200 : 32'h40);
            chk($sformatf("rr%0d.mem_wmask", k), 32'(mem_wmask), 32'h0);
            chk($sformatf("rr%0d.stall", k),    32'(stall), 32'h1);
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            chk($sformatf("rr%0d.if_ack", k),  32'(if_ack), exp_ls ? 32'h0 : 32'h1);
            chk($sformatf("rr%0d.ls_ack", k),  32'(ls_ack), exp_ls ? 32'h1 : 32'h0);
            chk($sformatf("rr%0d.rdata", k),   exp_ls ? ls_rdata : if_rdata, 32'h5000 + 32'(k));
            chk($sformatf("rr%0d.mem_req_ack", k), 32'(mem_req), 32'h0);
            chk($sformatf("rr%0d.stall_ack", k), 32'(stall), 32'h1);
        end
        if_req = 1'b0; ls_req = 1'b0;

        // LS load with no MEM_ACK
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
        @(negedge clk);
        #1;
        chk("to.mem_req_grant", 32'(mem_req), 32'h1);
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        for (int j = 2; j <= 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to.mem_req_c%0d", j), 32'(mem_req), 32'h1);
            chk($sformatf("to.ls_ack_c%0d", j),  32'(ls_ack),  32'h0);
        end
        @(negedge clk);
        #1;
        chk("to.ls_ack",   32'(ls_ack),  32'h1);
        chk("to.bus_err",  32'(bus_err), 32'h1);
        chk("to.ls_rdata", ls_rdata,     32'h0);
        chk("to.mem_req",  32'(mem_req), 32'h0);
        ls_req = 1'b0;
        @(negedge clk);
        #1;
        chk("to.ls_ack_end",  32'(ls_ack),  32'h0);
        chk("to.bus_err_end", 32'(bus_err), 32'h0);
        ls_req = 1'b1; ls_addr = 32'h400;
        @(negedge clk);
        #1;
        chk("rs.busy", 32'(mem_req), 32'h1);
`else
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to.mem_req_c%0d", j), 32'(mem_req), 32'h1);
            chk($sformatf("to.bus_err_c%0d", j), 32'(bus_err), 32'h0);
            chk($sformatf("to.ls_ack_c%0d", j),  32'(ls_ack),  32'h0);
        end
`endif

        // Asynchronous reset in the middle of BUSY_LS
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs.mem_req",  32'(mem_req), 32'h0);
        chk("rs.ls_ack",   32'(ls_ack),  32'h0);
        chk("rs.mem_addr", mem_addr,     32'h0);
        chk("rs.ls_rdata", ls_rdata,     32'h0);
        chk("rs.if_rdata", if_rdata,     32'h0);
        ls_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rs.late_ls_ack",  32'(ls_ack),  32'h0);
        chk("rs.late_ls_rdata", ls_rdata,    32'h0);
        chk("rs.late_mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        #1;
        chk("rs.idle_ls_ack",  32'(ls_ack),  32'h0);
        chk("rs.idle_stall",   32'(stall),   32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
